// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed, checksummed byte stream
// assembled into little-endian 32-bit words; holds the core in reset until a good image lands.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]       byte_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      len_q;
    logic [23:0]      asm_q;
    logic [7:0]       csum_q;

    logic        accept;
    logic        can_start;
    logic        fourth_byte;
    logic        last_word;
    logic        len_bad;
    logic [31:0] len_full;

    assign accept      = in_valid && in_ready;
    assign can_start   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign fourth_byte = accept && (byte_cnt == 2'd3);
    assign len_full    = {in_data, len_q[31:8]};
    // Full 32-bit compare so large upper bytes are rejected rather than wrapped.
    assign len_bad     = (len_full == 32'd0) || (len_full > 32'(DEPTH_WORDS));
    assign last_word   = (32'(word_idx) == (len_q - 32'd1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nx = S_LEN;
                end
            end
            S_LEN: begin
                if (fourth_byte) begin
                    state_nx = len_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (fourth_byte && last_word) begin
                    state_nx = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_nx = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they move on the same edge as the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_rst  <= 1'b0;
        end else begin
            in_ready <= (state_nx == S_LEN) || (state_nx == S_DATA) || (state_nx == S_CSUM);
            busy     <= (state_nx == S_LEN) || (state_nx == S_DATA) || (state_nx == S_CSUM);
            done     <= (state_nx == S_DONE);
            error    <= (state_nx == S_ERR);
            cpu_rst  <= (state_nx == S_DONE);
        end
    end

    // Length capture, word assembly, checksum and memory write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= 2'd0;
            word_idx <= '0;
            len_q    <= 32'd0;
            asm_q    <= 24'd0;
            csum_q   <= 8'd0;
            mem_we   <= 1'b0;
            mem_addr <= 32'd0;
            mem_wd   <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (can_start && start) begin
                byte_cnt <= 2'd0;
                word_idx <= '0;
                csum_q   <= 8'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (state)
                    S_LEN: begin
                        len_q <= len_full;
                    end
                    S_DATA: begin
                        csum_q <= csum_q + in_data;
                        asm_q  <= {in_data, asm_q[23:8]};
                        if (byte_cnt == 2'd3) begin
                            mem_we   <= 1'b1;
                            mem_wd   <= {in_data, asm_q};
                            mem_addr <= 32'(word_idx) << 2;
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized images
// compared against a stream-parsing reference model.
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [63:0] got_wr[$];
    logic [63:0] exp_wr[$];
    logic [7:0]  stream[$];

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) got_wr.push_back({mem_addr, mem_wd});

    // Stream image: 4 length bytes, payload (only when the length is legal), checksum + delta
    function automatic void build(input logic [31:0] len, input logic [31:0] words[$],
                                  input logic [7:0] delta);
        logic [7:0] sum;
        sum = 8'd0;
        stream.delete();
        for (int b = 0; b < 4; b++) stream.push_back(len[8*b +: 8]);
        if (len == 32'd0 || len > DEPTH) return;
        foreach (words[k]) begin
            for (int b = 0; b < 4; b++) begin
                stream.push_back(words[k][8*b +: 8]);
                sum = sum + words[k][8*b +: 8];
            end
        end
        stream.push_back(sum + delta);
    endfunction

    // Reference model: parse the stream and predict writes and the final flag
    task automatic model(output bit e_done, output bit e_err);
        int unsigned n;
        int unsigned s;
        logic [31:0] w;
        n = {stream[3], stream[2], stream[1], stream[0]};
        exp_wr.delete();
        if (n == 0 || n > DEPTH) begin
            e_done = 1'b0;
            e_err  = 1'b1;
            return;
        end
        s = 0;
        for (int k = 0; k < int'(n); k++) begin
            w = {stream[4+4*k+3], stream[4+4*k+2], stream[4+4*k+1], stream[4+4*k]};
            exp_wr.push_back({32'(4*k), w});
            s += w[7:0] + w[15:8] + w[23:16] + w[31:24];
        end
        e_done = (8'(s) == stream[4+4*n]);
        e_err  = !e_done;
    endtask

    task automatic do_start(output int unsigned s_cyc);
        start = 1'b1;
        @(posedge clk); #1;
        s_cyc = cyc;
        start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: valid toggles every other cycle, 2: random gaps
    task automatic send(input int n_bytes, input int mode);
        bit acc;
        for (int i = 0; i < n_bytes; i++) begin
            int gaps;
            gaps = (mode == 1 && i > 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL byte_accept: byte %0d not accepted, in_ready=%0b required 1", i, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_end(output int unsigned e_cyc);
        for (int t = 0; t < 100 && !(done || error); t++) begin
            @(posedge clk); #1;
        end
        e_cyc = cyc;
        if (!(done || error)) begin
            checks++; errors++;
            $display("FAIL end_timeout: done=%0b error=%0b required one of them 1", done, error);
        end
    endtask

    task automatic run(input int mode, output int unsigned e_cyc);
        got_wr.delete();
        send(stream.size(), mode);
        wait_end(e_cyc);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wd, cpu_rst, busy, done, error} !== 70'd0) begin
            errors++;
            $display("FAIL reset_values: got %h required 0",
                     {in_ready, mem_we, mem_addr, mem_wd, cpu_rst, busy, done, error});
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, busy, done, error, cpu_rst} !== 5'd0) begin
            errors++;
            $display("FAIL idle_hold: got %b required 00000", {in_ready, busy, done, error, cpu_rst});
        end
    endtask

    task automatic test_basic(input int mode, input string name);
        logic [31:0] w[$];
        int unsigned s_cyc, e_cyc;
        bit ed, ee;
        w = '{32'h0050_0093, 32'h00A0_0113};
        build(32'd2, w, 8'd0);
        model(ed, ee);
        do_start(s_cyc);
        run(mode, e_cyc);
        checks++;
        if (got_wr.size() !== exp_wr.size()) begin
            errors++;
            $display("FAIL %s_wr_count: got %0d required %0d", name, got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            checks++;
            if (got_wr[i] !== exp_wr[i]) begin
                errors++;
                $display("FAIL %s_wr%0d: got %h required %h", name, i, got_wr[i], exp_wr[i]);
            end
        end
        checks++;
        if ({done, error, cpu_rst, busy, in_ready} !== {ed, ee, ed, 2'b00}) begin
            errors++;
            $display("FAIL %s_flags: got %b required %b", name,
                     {done, error, cpu_rst, busy, in_ready}, {ed, ee, ed, 2'b00});
        end
        // start cycle plus 13 accepting cycles: done is visible on the 14th cycle
        if (mode == 0) begin
            checks++;
            if (e_cyc - s_cyc !== 13) begin
                errors++;
                $display("FAIL %s_latency: got %0d required 13", name, e_cyc - s_cyc);
            end
        end
    endtask

    task automatic test_bad_len();
        logic [31:0] lens[3];
        logic [31:0] w[$];
        int unsigned s_cyc, e_cyc;
        lens = '{32'd0, 32'(DEPTH + 1), 32'h0100_0001};
        w.delete();
        foreach (lens[i]) begin
            build(lens[i], w, 8'd0);
            do_start(s_cyc);
            run(0, e_cyc);
            checks++;
            if ({error, done, cpu_rst, busy, in_ready} !== 5'b10000 || got_wr.size() != 0) begin
                errors++;
                $display("FAIL bad_len_%h: flags %b writes %0d required 10000 and 0 writes",
                         lens[i], {error, done, cpu_rst, busy, in_ready}, got_wr.size());
            end
        end
    endtask

    task automatic test_bad_csum();
        logic [31:0] w[$];
        int unsigned s_cyc, e_cyc;
        bit ed, ee;
        w = '{32'h0050_0093, 32'h00A0_0113};
        build(32'd2, w, 8'd1);
        model(ed, ee);
        do_start(s_cyc);
        run(0, e_cyc);
        checks++;
        if (got_wr.size() !== 2 || got_wr[0] !== exp_wr[0] || got_wr[1] !== exp_wr[1]) begin
            errors++;
            $display("FAIL bad_csum_writes: got %0d writes, required %0d matching model", got_wr.size(), 2);
        end
        checks++;
        if ({error, done, cpu_rst} !== {ee, ed, 1'b0} || ee !== 1'b1) begin
            errors++;
            $display("FAIL bad_csum_flags: got %b required 100", {error, done, cpu_rst});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[$];
        int unsigned s_cyc, e_cyc;
        bit ed, ee;
        w = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        build(32'd3, w, 8'd0);
        do_start(s_cyc);
        got_wr.delete();
        send(10, 0);
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wd, cpu_rst, busy, done, error} !== 70'd0) begin
            errors++;
            $display("FAIL mid_reset_values: got %h required 0",
                     {in_ready, mem_we, mem_addr, mem_wd, cpu_rst, busy, done, error});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        model(ed, ee);
        do_start(s_cyc);
        run(2, e_cyc);
        checks++;
        if (got_wr.size() !== exp_wr.size() || got_wr[2] !== exp_wr[2]) begin
            errors++;
            $display("FAIL mid_reset_reload_wr: got %0d writes, required %0d", got_wr.size(), exp_wr.size());
        end
        checks++;
        if ({done, error, cpu_rst} !== 3'b101) begin
            errors++;
            $display("FAIL mid_reset_reload_flags: got %b required 101", {done, error, cpu_rst});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[$];
        int unsigned s_cyc, e_cyc;
        bit ed, ee;
        w = '{32'hDEAD_BEEF};
        build(32'd1, w, 8'd0);
        model(ed, ee);
        if (!done) begin
            checks++; errors++;
            $display("FAIL b2b_precondition: done=%0b required 1", done);
        end
        do_start(s_cyc);
        checks++;
        if ({cpu_rst, done, busy, in_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_restart: got %b required 0011", {cpu_rst, done, busy, in_ready});
        end
        run(2, e_cyc);
        checks++;
        if (got_wr.size() !== 1 || got_wr[0] !== exp_wr[0]) begin
            errors++;
            $display("FAIL b2b_write: got %0d writes first %h required 1 write %h",
                     got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 64'd0, exp_wr[0]);
        end
        checks++;
        if ({done, error, cpu_rst} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_flags: got %b required 101", {done, error, cpu_rst});
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] w[$];
        int unsigned s_cyc, e_cyc;
        bit ed, ee;
        w.delete();
        for (int k = 0; k < int'(DEPTH); k++) w.push_back($urandom);
        build(32'(DEPTH), w, 8'd0);
        model(ed, ee);
        do_start(s_cyc);
        run(0, e_cyc);
        checks++;
        if (got_wr.size() !== exp_wr.size() || got_wr[DEPTH-1] !== exp_wr[DEPTH-1]
            || got_wr[DEPTH-1][63:32] !== 32'(4*(DEPTH-1))) begin
            errors++;
            $display("FAIL full_depth_wr: got %0d writes last %h required %0d last %h", got_wr.size(),
                     got_wr[got_wr.size()-1], exp_wr.size(), exp_wr[DEPTH-1]);
        end
        checks++;
        if (e_cyc - s_cyc !== 4 + 4*DEPTH + 1 || {done, cpu_rst} !== 2'b11) begin
            errors++;
            $display("FAIL full_depth_done: cycles %0d flags %b required %0d and 11",
                     e_cyc - s_cyc, {done, cpu_rst}, 4 + 4*DEPTH + 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] len;
        logic [7:0]  delta;
        int unsigned s_cyc, e_cyc;
        bit ed, ee;
        for (int it = 0; it < 12; it++) begin
            w.delete();
            len = 32'($urandom_range(1, 6));
            for (int k = 0; k < int'(len); k++) w.push_back($urandom);
            if ($urandom_range(0, 5) == 0) len = 32'(DEPTH) + 32'($urandom_range(1, 9));
            delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            build(len, w, delta);
            model(ed, ee);
            do_start(s_cyc);
            run(2, e_cyc);
            checks++;
            if (got_wr.size() !== exp_wr.size()) begin
                errors++;
                $display("FAIL rand%0d_wr_count: got %0d required %0d", it, got_wr.size(), exp_wr.size());
            end
            for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
                checks++;
                if (got_wr[i] !== exp_wr[i]) begin
                    errors++;
                    $display("FAIL rand%0d_wr%0d: got %h required %h", it, i, got_wr[i], exp_wr[i]);
                end
            end
            checks++;
            if ({done, error, cpu_rst, busy} !== {ed, ee, ed, 1'b0}) begin
                errors++;
                $display("FAIL rand%0d_flags: got %b required %b", it,
                         {done, error, cpu_rst, busy}, {ed, ee, ed, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_basic(1, "toggle");
        test_bad_len();
        test_bad_csum();
        test_reset_mid();
        test_back_to_back();
        test_full_depth();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
